mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// Shares one single-ported unified memory between instruction fetch (I) and load/store (D) requesters.
// Sits between the PC/fetch stage, the data path (driven by MemWrite/ResultSrc decode) and the memory.
// Grants one requester at a time and keeps at most one transaction outstanding.
// Raises stall_o to hold the PC and regfile write while a request is waiting.
// PARAMETERS
// ADDR_W       32  address width
// DATA_W       32  data width (matches DATA_BUS)
// TIMEOUT_CYC  16  max WAIT cycles before abort; legal range 2..255
// PORTS
// clk          in   1       clock, rising edge
// rst_n        in   1       asynchronous, active-low reset
// if_req_i     in   1       fetch request; held until if_gnt_o
// if_addr_i    in   ADDR_W  fetch address
// if_gnt_o     out  1       fetch accepted (1-cycle pulse)
// if_rvalid_o  out  1       fetch data valid (1-cycle pulse)
// if_rdata_o   out  DATA_W  fetch data; 0 when !if_rvalid_o
// d_req_i      in   1       data request; held until d_gnt_o
// d_we_i       in   1       1=store, 0=load
// d_addr_i     in   ADDR_W  data address (ALU result)
// d_wdata_i    in   DATA_W  store data
// d_gnt_o      out  1       data accepted (1-cycle pulse)
// d_rvalid_o   out  1       load data / store ack (1-cycle pulse)
// d_rdata_o    out  DATA_W  load data; 0 for stores and when !d_rvalid_o
// mem_req_o    out  1       memory request strobe (1 cycle)
// mem_we_o     out  1       memory write enable
// mem_addr_o   out  ADDR_W  memory address (registered)
// mem_wdata_o  out  DATA_W  memory write data (registered)
// mem_rvalid_i in   1       memory response / write ack
// mem_rdata_i  in   DATA_W  memory read data
// stall_o      out  1       hold PC/pipeline
// err_o        out  1       timeout pulse (1 cycle)
// BEHAVIOUR
// - Reset: state=IDLE. All outputs 0. Owner, timeout counter and RR pointer cleared (pointer favours D).
// - FSM IDLE:
//   - Any req: pick winner, pulse its gnt, capture addr/wdata/we/owner, go to ISSUE.
//   - No req: stay in IDLE.
// - FSM ISSUE: mem_req_o=1 for exactly one cycle, then go to WAIT; counter=0.
// - FSM WAIT:
//   - On mem_rvalid_i: route it combinationally to the owner's rvalid/rdata in the same cycle, go to IDLE.
//   - Otherwise increment counter.
//   - Counter == TIMEOUT_CYC-1 without rvalid: pulse err_o, no rvalid to owner, go to IDLE.
// - Latency: gnt at cycle N, mem_req_o at N+1, owner rvalid at N+1+L (L>=1 is memory latency).
//   - A new grant is possible no earlier than the cycle after rvalid (IDLE).
// - Priority (default): D beats I when both are requested in IDLE.
//   - D belongs to the instruction already in flight, so fetch must wait.
// - stall_o = (if_req_i|d_req_i) & !(owner rvalid this cycle). Computed combinationally.
// - mem_rvalid_i outside WAIT (stale/late): ignored, no output effect.
// - Requester drops req before gnt: no transaction issued. Arbitration is re-evaluated every IDLE cycle.
// - Req dropped after gnt: the transaction still completes and the response is still delivered.
// - rst_n low mid-transaction: abort immediately, return to IDLE. Any later response is ignored per the rule above.
// - mem_addr_o/mem_wdata_o/mem_we_o hold their captured values until the next grant.
// CONFIGURATION
// ARB_RR_EN defined:
//   - Round-robin on contention: the last owner loses the next tie. The pointer updates on every grant.
//   - Prevents fetch starvation by back-to-back D.
// ARB_RR_EN undefined: fixed D-over-I priority, no pointer register.
// STRUCTURE
// types_pkg additions:
//   - arb_state_t enum {IDLE, ISSUE, WAIT}
//   - arb_owner_t enum {OWN_I, OWN_D}
//   - TIMEOUT counter width localparam
// No sub-module: a single FSM plus capture registers.
// TESTING
// 1 Lone fetch, addr 0x0000_0010, L=2 -> gnt@N, mem_req_o@N+1, if_rvalid_o@N+3, data 0x00A00093.
// 2 I and D requested same cycle, D=load 0x100 -> D granted first; I granted the cycle after d_rvalid_o.
//   - With ARB_RR_EN, a second tie goes to I.
// 3 Store 0x104 <= 0xDEADBEEF -> mem_we_o=1, mem_wdata_o=0xDEADBEEF; d_rvalid_o on ack; d_rdata_o=0.
// 4 No mem_rvalid_i for 16 WAIT cycles -> err_o pulse, no rvalid, IDLE. A late mem_rvalid_i is ignored.
// 5 rst_n low in WAIT, then high -> all outputs 0, IDLE. A pending response is not forwarded.
// 6 stall_o = 1 from req until the rvalid cycle; 0 in the rvalid cycle and whenever no request is pending.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the I/D memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Wide enough for the largest legal TIMEOUT_CYC (255)
    localparam int ARB_CNT_W = 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding I/D arbiter for one unified memory port
// Optional build macro ARB_RR_EN selects round-robin tie breaking instead of fixed D-over-I priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam logic [ARB_CNT_W-1:0] CNT_LAST = ARB_CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t            state_q, state_d;
    arb_owner_t            owner_q, winner;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [ARB_CNT_W-1:0]  cnt_q;
    logic                  grant, resp, timeout;

`ifdef ARB_RR_EN
    // Set when D should win the next tie; cleared after every D grant
    logic rr_d_q;

    always_comb begin
        winner = OWN_I;
        if (d_req_i && (!if_req_i || rr_d_q)) begin
            winner = OWN_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_d_q <= 1'b1;
        end else if (grant) begin
            rr_d_q <= (winner == OWN_I);
        end
    end
`else
    always_comb begin
        winner = d_req_i ? OWN_D : OWN_I;
    end
`endif

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        resp    = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req_i || d_req_i) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    resp    = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= winner;
                we_q    <= (winner == OWN_D) ? d_we_i : 1'b0;
                addr_q  <= (winner == OWN_D) ? d_addr_i : if_addr_i;
                wdata_q <= (winner == OWN_D) ? d_wdata_i : '0;
            end
            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == WAIT && !mem_rvalid_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign if_gnt_o    = grant && (winner == OWN_I);
    assign d_gnt_o     = grant && (winner == OWN_D);
    assign if_rvalid_o = resp && (owner_q == OWN_I);
    assign d_rvalid_o  = resp && (owner_q == OWN_D);
    // Store acks carry no data, so D read data is masked for writes
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = (d_rvalid_o && !we_q) ? mem_rdata_i : '0;
    assign mem_req_o   = (state_q == ISSUE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign err_o       = timeout;
    assign stall_o     = (if_req_i || d_req_i) && !(if_rvalid_o || d_rvalid_o);

endmodule
